// File: rtl/ring_johnson_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ring_johnson_counter
//  Brief    : Parametrised ring / Johnson shift counter with direction, enable,
//             parallel load, illegal-state self-correction and wrap pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module ring_johnson_counter #(
    parameter int DATA_WID = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                dir,
    input  logic                load,
    input  logic [DATA_WID-1:0] load_val,
    output logic [DATA_WID-1:0] Ring_Count,
    output logic                wrap,
    output logic                err
);

    typedef logic [DATA_WID-1:0] t_cnt;
    typedef logic [DATA_WID-2:0] t_bnd;

    localparam t_cnt c_SEED = t_cnt'(1);
    localparam t_bnd c_BND_ONE = t_bnd'(1);

    logic [DATA_WID-1:0] r_count;
    logic                r_wrap;
    logic                r_err;

    logic [DATA_WID-1:0] w_shift;
    logic [DATA_WID-1:0] w_next;
    logic                w_wrap;
    logic                w_err;

    // Ring: exactly one bit set. Johnson: at most one boundary between
    // adjacent bits, i.e. the adjacent-difference vector is zero or one-hot.
    function automatic logic f_legal(input logic m, input t_cnt v);
        t_bnd d;
        d = v[DATA_WID-2:0] ^ v[DATA_WID-1:1];
        if (m) begin
            return ((d & (d - c_BND_ONE)) == '0);
        end
        return (v != '0) && ((v & (v - c_SEED)) == '0);
    endfunction

    always_comb begin
        w_shift = r_count;
        if (dir) begin
            w_shift = {(mode ? ~r_count[0] : r_count[0]), r_count[DATA_WID-1:1]};
        end else begin
            w_shift = {r_count[DATA_WID-2:0], (mode ? ~r_count[DATA_WID-1] : r_count[DATA_WID-1])};
        end
    end

    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        w_err  = 1'b0;
        if (load) begin
            if (f_legal(mode, load_val)) begin
                w_next = load_val;
            end else begin
                w_next = c_SEED;
                w_err  = 1'b1;
            end
        end else if (en) begin
            // An illegal state is replaced rather than shifted this cycle.
            if (!f_legal(mode, r_count)) begin
                w_next = c_SEED;
                w_err  = 1'b1;
            end else begin
                w_next = w_shift;
                w_wrap = (w_shift == c_SEED);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_SEED;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap;
            r_err   <= w_err;
        end
    end

    assign Ring_Count = r_count;
    assign wrap       = r_wrap;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_johnson_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_johnson_counter
//  Brief    : Scoreboard bench for ring_johnson_counter at widths 2, 4 and 8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_johnson_counter;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [7:0] lv;

    logic [1:0] c2;
    logic [3:0] c4;
    logic [7:0] c8;
    logic       wr2, wr4, wr8, er2, er4, er8;

    always #5 clk = ~clk;

    ring_johnson_counter #(.DATA_WID(2)) u_w2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv[1:0]), .Ring_Count(c2), .wrap(wr2), .err(er2));
    ring_johnson_counter #(.DATA_WID(4)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv[3:0]), .Ring_Count(c4), .wrap(wr4), .err(er4));
    ring_johnson_counter #(.DATA_WID(8)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(lv), .Ring_Count(c8), .wrap(wr8), .err(er8));

    typedef struct packed {
        logic [2:0][7:0] c;
        logic [2:0]      w;
        logic [2:0]      e;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_state [3];
    int         widths  [3] = '{2, 4, 8};

    // p-th pattern of the sequence that starts at SEED and steps leftwards.
    function automatic logic [7:0] pat(input int w, input logic md, input int p);
        logic [7:0] ones;
        ones = 8'((1 << w) - 1);
        if (!md) return 8'(1 << p);
        if (p < w) return 8'((1 << (p + 1)) - 1);
        return (ones << (p - w + 1)) & ones;
    endfunction

    function automatic int find(input int w, input logic md, input logic [7:0] v);
        int per;
        per = md ? 2 * w : w;
        for (int p = 0; p < per; p++)
            if (pat(w, md, p) == v) return p;
        return -1;
    endfunction

    task automatic step_model(input logic r, input logic e, input logic md,
                              input logic d, input logic ld, input logic [7:0] lvv);
        exp_t x;
        x = '0;
        for (int i = 0; i < 3; i++) begin
            int         w, p, per;
            logic [7:0] lvm, nxt;
            logic       wf, ef;
            w   = widths[i];
            lvm = lvv & 8'((1 << w) - 1);
            nxt = m_state[i];
            wf  = 1'b0;
            ef  = 1'b0;
            per = md ? 2 * w : w;
            if (r) begin
                nxt = 8'd1;
            end else if (ld) begin
                if (find(w, md, lvm) >= 0) nxt = lvm;
                else begin nxt = 8'd1; ef = 1'b1; end
            end else if (e) begin
                p = find(w, md, m_state[i]);
                if (p < 0) begin
                    nxt = 8'd1; ef = 1'b1;
                end else begin
                    p   = d ? (p + per - 1) % per : (p + 1) % per;
                    nxt = pat(w, md, p);
                    wf  = (p == 0);
                end
            end
            m_state[i] = nxt;
            x.c[i] = nxt;
            x.w[i] = wf;
            x.e[i] = ef;
        end
        sb.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic e, input logic md, input logic d,
                       input logic ld, input logic [7:0] lvv);
        @(negedge clk);
        rst = r; en = e; mode = md; dir = d; load = ld; lv = lvv;
        step_model(r, e, md, d, ld, lvv);
    endtask

    function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endfunction

    exp_t mx;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            check("cnt_w2", {6'd0, c2}, mx.c[0]);
            check("cnt_w4", {4'd0, c4}, mx.c[1]);
            check("cnt_w8", c8,         mx.c[2]);
            check("wrap_w2", {7'd0, wr2}, {7'd0, mx.w[0]});
            check("wrap_w4", {7'd0, wr4}, {7'd0, mx.w[1]});
            check("wrap_w8", {7'd0, wr8}, {7'd0, mx.w[2]});
            check("err_w2", {7'd0, er2}, {7'd0, mx.e[0]});
            check("err_w4", {7'd0, er4}, {7'd0, mx.e[1]});
            check("err_w8", {7'd0, er8}, {7'd0, mx.e[2]});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout scoreboard_left=%0d required=0", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic md, d;
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; lv = '0;
        for (int i = 0; i < 3; i++) m_state[i] = 8'd1;

        // Reset then ring left, Johnson left
        cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 17; k++) cyc(0, 1, 1, 0, 0, 0);
        // Right shifts in both modes
        cyc(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 9; k++) cyc(0, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        for (int k = 0; k < 17; k++) cyc(0, 1, 1, 1, 0, 0);
        // Loads: legal, illegal, load beats enable
        cyc(0, 0, 0, 0, 1, 8'h04);
        cyc(0, 0, 0, 0, 1, 8'h06);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 8'h08);
        cyc(0, 0, 1, 0, 1, 8'h05);
        // Johnson state left illegal by a switch to ring
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0);
        // Reset mid-sequence with load and enable asserted
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 8'h0F);

        // Randomized phase
        md = 1'b0; d = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            logic       r, e, ld;
            logic [7:0] v;
            if ($urandom_range(0, 39) == 0) md = ~md;
            if ($urandom_range(0, 39) == 0) d  = ~d;
            r  = ($urandom_range(0, 149) == 0);
            e  = ($urandom_range(0, 4) != 0);
            ld = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       v = 8'($urandom);
                1:       v = pat(8, md, int'($urandom_range(0, 15)) % (md ? 16 : 8));
                default: v = pat(4, md, int'($urandom_range(0, 7)) % (md ? 8 : 4));
            endcase
            cyc(r, e, md, d, ld, v);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
